// File: rtl/bus_pkg.sv
// bus_pkg: shared bus width, default FIFO depth and bus word type
package bus_pkg;
   localparam int BUS_WIDTH = 32;
   localparam int FIFO_DEPTH = 4;
   typedef logic [BUS_WIDTH-1:0] bus_word_t;
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: FIFO storage and pointers with sync write and registered head-of-queue read
module fifo_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic             re,
   input  logic             byp,
   input  logic             hd,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr, rptr_n;
   assign rptr_n = rptr + AW'(re);
   always_ff @(posedge clk)
      if (we) mem[wptr] <= wdata;
   // rdata tracks the head after this edge: the incoming word when it lands in an empty queue
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wptr  <= '0;
         rptr  <= '0;
         rdata <= '0;
      end else begin
         wptr  <= wptr + AW'(we);
         rptr  <= rptr_n;
         rdata <= byp ? wdata : hd ? mem[rptr_n] : rdata;
      end
endmodule

// File: rtl/bus_rx_fifo.sv
// bus_rx_fifo: tri-state bus capture FIFO with sticky overflow; BUS_RX_PARITY_EN adds bus_par/par_err
module bus_rx_fifo
   import bus_pkg::*;
#(
   parameter int WIDTH = BUS_WIDTH,
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [WIDTH-1:0]       bus_in,
`ifdef BUS_RX_PARITY_EN
   input  logic                   bus_par,
   output logic                   par_err,
   input  logic                   bus_en,
`else
   input  logic                   bus_en,
`endif
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   ovf
);
   localparam int LW = $clog2(DEPTH) + 1;
   logic full, push, pop;
   logic [LW-1:0] lvl_pop;
   assign full      = level == LW'(DEPTH);
   assign out_valid = level != '0;
   assign pop       = out_valid & out_ready;
   assign push      = bus_en & (~full | pop);
   assign lvl_pop   = level - LW'(pop);
   fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (push),
      .re    (pop),
      .byp   (push && lvl_pop == '0),
      .hd    (lvl_pop != '0),
      .wdata (bus_in),
      .rdata (out_data)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         level <= '0;
         ovf   <= 1'b0;
      end else begin
         level <= lvl_pop + LW'(push);
         ovf   <= ovf | (bus_en & full & ~pop);
      end
`ifdef BUS_RX_PARITY_EN
   // even parity: bus_par must equal the XOR of all bus_in bits
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) par_err <= 1'b0;
      else        par_err <= par_err | (push & (^bus_in ^ bus_par));
`endif
endmodule

// File: tb/tb_bus_rx_fifo.sv
// tb_bus_rx_fifo: randomized and directed checks of bus_rx_fifo against a queue model
module tb_bus_rx_fifo;
   import bus_pkg::*;
   localparam int DEPTH = FIFO_DEPTH;
   logic clk = 1'b0, rst_n = 1'b0, bus_en = 1'b0, out_ready = 1'b0;
   bus_word_t bus_in = '0, out_data;
   logic out_valid, ovf;
   logic [$clog2(DEPTH):0] level;
   int n_tests = 0, n_fail = 0;
   bus_word_t q[$];
   bus_word_t m_data = '0;
   bit m_ovf = 1'b0;
`ifdef BUS_RX_PARITY_EN
   logic bus_par = 1'b0, par_err;
   bit par_bad = 1'b0, m_perr = 1'b0;
`endif
   always #5 clk = ~clk;
   bus_rx_fifo #(.WIDTH(BUS_WIDTH), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus_in    (bus_in),
`ifdef BUS_RX_PARITY_EN
      .bus_par   (bus_par),
      .par_err   (par_err),
`endif
      .bus_en    (bus_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .level     (level),
      .ovf       (ovf)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic check_all();
      chk("level", 64'(level), 64'(q.size()));
      chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
      chk("out_data", 64'(out_data), 64'(m_data));
      chk("ovf", 64'(ovf), 64'(m_ovf));
`ifdef BUS_RX_PARITY_EN
      chk("par_err", 64'(par_err), 64'(m_perr));
`endif
   endtask
   task automatic model_clear();
      q.delete();
      m_data = '0;
      m_ovf = 1'b0;
`ifdef BUS_RX_PARITY_EN
      m_perr = 1'b0;
`endif
   endtask
   task automatic step(input logic en, input bus_word_t d, input logic rdy);
      bit pop, full;
      @(negedge clk);
      bus_en = en;
      bus_in = d;
      out_ready = rdy;
`ifdef BUS_RX_PARITY_EN
      bus_par = ^d ^ par_bad;
`endif
      @(posedge clk);
      pop = q.size() != 0 && rdy;
      full = q.size() == DEPTH;
      if (pop) void'(q.pop_front());
      if (en && (!full || pop)) begin
         q.push_back(d);
`ifdef BUS_RX_PARITY_EN
         if (par_bad) m_perr = 1'b1;
`endif
      end else if (en) m_ovf = 1'b1;
      if (q.size() != 0) m_data = q[0];
      #1;
      check_all();
   endtask
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      bus_en = 1'b0;
      model_clear();
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   initial begin
      int rp;
      do_reset();
      step(1'b1, 32'h0000FFFF, 1'b0);
      chk("first_push_data", 64'(out_data), 64'h0000FFFF);
      chk("first_push_level", 64'(level), 64'd1);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b0, 32'hFFFF0000, 1'b1);
      chk("idle_level", 64'(level), 64'd0);
      for (int i = 1; i <= 5; i++) step(1'b1, bus_word_t'(i), 1'b0);
      chk("ovf_level", 64'(level), 64'd4);
      chk("ovf_flag", 64'(ovf), 64'd1);
      for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
      chk("drained_data", 64'(out_data), 64'd4);
      do_reset();
      for (int i = 1; i <= 4; i++) step(1'b1, bus_word_t'(i), 1'b0);
      step(1'b1, 32'hAA, 1'b1);
      chk("full_pp_level", 64'(level), 64'd4);
      chk("full_pp_ovf", 64'(ovf), 64'd0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      chk("aa_last", 64'(out_data), 64'hAA);
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("async_level", 64'(level), 64'd0);
      chk("async_valid", 64'(out_valid), 64'd0);
      chk("async_ovf", 64'(ovf), 64'd0);
      chk("async_data", 64'(out_data), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
`ifdef BUS_RX_PARITY_EN
      par_bad = 1'b1;
      step(1'b1, 32'h1, 1'b0);
      chk("par_err_set", 64'(par_err), 64'd1);
      par_bad = 1'b0;
      step(1'b1, 32'h3, 1'b0);
      chk("par_err_hold", 64'(par_err), 64'd1);
      do_reset();
`endif
      rp = 50;
      for (int i = 0; i < 600; i++) begin
         if (i % 50 == 0) rp = $urandom_range(90, 10);
`ifdef BUS_RX_PARITY_EN
         par_bad = $urandom_range(39) == 0;
`endif
         if ($urandom_range(149) == 0) do_reset();
         else step($urandom_range(3) != 0, $urandom, $urandom_range(99) < rp);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_rx_fifo.md
BUS_RX_FIFO -- requirements
Module: bus_rx_fifo

Interface
REQ-001 Parameter WIDTH, default 32: bus and data word width in bits.
REQ-002 Parameter DEPTH, default 4: FIFO entries; power of two, minimum 2.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 bus_in  in  WIDTH  shared tri-state data bus, read side.
REQ-006 bus_en  in  1  driver enable of the bus-side tri-state buffer; high means bus_in carries a valid word this cycle.
REQ-007 out_data  out  WIDTH  head-of-FIFO word.
REQ-008 out_valid  out  1  out_data is valid.
REQ-009 out_ready  in  1  consumer accepts out_data.
REQ-010 level  out  log2(DEPTH)+1  current number of stored words.
REQ-011 ovf  out  1  sticky flag: a bus word was dropped.

Function
REQ-012 Push: each rising edge with bus_en=1 and (not full, or pop in the same cycle) SHALL store bus_in at the write pointer.
REQ-013 Pop: each rising edge with out_valid=1 and out_ready=1 SHALL advance the read pointer.
REQ-014 Latency: a word pushed at edge N SHALL appear on out_data with out_valid=1 after edge N; no combinational bus_in-to-out_data path.
REQ-015 Ordering: words SHALL leave in arrival order.
REQ-016 Empty: out_valid=0, and out_data holds its last value; out_ready has no effect.
REQ-017 Full (level=DEPTH) with bus_en=1 and no pop: the word SHALL be dropped, with no state change except ovf<=1.
REQ-018 Full with simultaneous push and pop: both SHALL complete; level stays DEPTH; ovf unchanged.
REQ-019 Simultaneous push and pop at any non-full level: level unchanged.
REQ-020 Pointers SHALL wrap modulo DEPTH; level SHALL count 0..DEPTH inclusive.
REQ-021 ovf SHALL remain 1 until reset.
REQ-022 Capture SHALL happen only when bus_en=1, so a floating or undriven bus_in (bus_en=0) is never stored.

Reset
REQ-023 While rst_n=0: level=0, out_valid=0, out_data=0, ovf=0, and both pointers=0.
REQ-024 Reset mid-transfer SHALL discard all stored words immediately, without waiting for a clock edge.
REQ-025 The first push SHALL be accepted at the first rising edge after rst_n deasserts.

Configuration
REQ-026 Macro BUS_RX_PARITY_EN: when defined, the block SHALL add input bus_par (1 bit, even parity over bus_in) and sticky output par_err.
REQ-027 With BUS_RX_PARITY_EN defined, a push with a parity mismatch SHALL store the word and set par_err=1 until reset; par_err SHALL reset to 0.
REQ-028 Without BUS_RX_PARITY_EN, bus_par and par_err SHALL not exist, and the remaining behaviour SHALL be identical.

Structure
REQ-029 The shared package bus_pkg SHALL hold the BUS_WIDTH constant (32), the default FIFO depth constant, and the bus word typedef.
REQ-030 Storage and pointers SHALL be a sub-module fifo_mem (sync write, registered read); flags, level, and parity logic SHALL stay in bus_rx_fifo.

Verification
REQ-031 Reset, then bus_en=1 with bus_in=0x0000FFFF for one cycle, out_ready=0 -> after the next edge out_valid=1, out_data=0x0000FFFF, level=1.
REQ-032 bus_en=0 while bus_in=0xFFFF0000 for 3 cycles -> level stays 0 and out_valid=0.
REQ-033 Push 0x1, 0x2, 0x3, 0x4, 0x5 back-to-back with out_ready=0 -> level=4, ovf=1; then out_ready=1 pops 0x1..0x4 in order and 0x5 never appears.
REQ-034 Full FIFO, with bus_en=1 (0xAA) and out_ready=1 in the same cycle -> level stays 4, ovf stays 0, and 0xAA exits last.
REQ-035 Assert rst_n=0 between clock edges with level=3 -> level=0, out_valid=0, ovf=0 without a clock edge.
REQ-036 With BUS_RX_PARITY_EN defined, push 0x00000001 with bus_par=0 -> word stored and par_err=1; then push 0x3 with bus_par=0 -> par_err remains 1.
